// File: rtl/dmem_arbiter_pkg.sv
// Shared types and helpers for the data-memory arbiter slice.
package tessia_mem_pkg;

  // Widest data/address bus the command register can hold
  localparam int DMEM_WIDTH = 64;
  // Widest requester id the command register can hold
  localparam int ID_MAX_W = 8;

  // One accepted memory command, held for exactly one cycle of memory drive
  typedef struct packed {
    logic                  we;
    logic [DMEM_WIDTH-1:0] addr;
    logic [DMEM_WIDTH-1:0] wdata;
    logic [ID_MAX_W-1:0]   id;
  } mem_cmd_t;

  // Bits needed to encode a requester index (at least one)
  function automatic int req_id_w(input int n_req);
    return (n_req > 2) ? $clog2(n_req) : 1;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side and memory-side bus of the data-memory arbiter.
//
// Handshake: requester i transfers a command in the cycle where
// req_valid[i] & req_ready[i] are both high. req_ready never asserts
// without req_valid, and a requester keeps req_* stable while it is
// valid and not yet ready. rsp_valid is a one-cycle pulse with no
// back-pressure; the requester must accept it when it appears.
interface dmem_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 64
);
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_we;
  logic [N_REQ*WIDTH-1:0] req_addr;
  logic [N_REQ*WIDTH-1:0] req_wdata;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]       rsp_rdata;
  logic                   mem_we;
  logic [WIDTH-1:0]       mem_a;
  logic [WIDTH-1:0]       mem_wd;
  logic [WIDTH-1:0]       mem_rd;

  // Arbiter side
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mem_rd,
    output req_ready, rsp_valid, rsp_rdata, mem_we, mem_a, mem_wd
  );

  // Requesters plus memory side
  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_rd,
    input  req_ready, rsp_valid, rsp_rdata, mem_we, mem_a, mem_wd
  );
endinterface

// File: rtl/dmem_arbiter_rr_arbiter.sv
// Round-robin grant logic: combinational one-hot grant starting at rr_ptr,
// pointer moves past the winner whenever a grant is taken.
module rr_arbiter
  import tessia_mem_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_REQ-1:0]             req,
  input  logic                         advance,
  output logic [N_REQ-1:0]             grant,
  output logic [req_id_w(N_REQ)-1:0]   grant_id,
  output logic [req_id_w(N_REQ)-1:0]   rr_ptr
);
  localparam int ID_W = req_id_w(N_REQ);

  logic found;
  int   idx;

  // Scan from rr_ptr upward with wrap; first pending requester wins
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(rr_ptr) + i) % N_REQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = ID_W'(idx);
      end
    end
  end

  // Pointer moves to the requester after the one just served
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (advance) begin
      rr_ptr <= (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port data memory among N_REQ requesters:
// accept in cycle t, drive memory in t+1, respond in t+2.
module dmem_arbiter
  import tessia_mem_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = DMEM_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset,
  dmem_arbiter_if.slave              bus,
  output logic [req_id_w(N_REQ)-1:0] rr_ptr
);
  localparam int ID_W = req_id_w(N_REQ);

  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  grant_id;
  logic             handshake;
  mem_cmd_t         cmd_q;
  logic             cmd_v;
  logic [N_REQ-1:0] rsp_valid_q;
  logic [WIDTH-1:0] rsp_rdata_q;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .clk      (clk),
    .reset    (reset),
    .req      (bus.req_valid),
    .advance  (handshake),
    .grant    (grant),
    .grant_id (grant_id),
    .rr_ptr   (rr_ptr)
  );

  assign bus.req_ready = grant;
  assign handshake     = |(grant & bus.req_valid);

  // Command register: load the granted request; fields hold when idle so
  // the memory address/data lines stay quiet between accesses
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_q <= '0;
      cmd_v <= 1'b0;
    end else begin
      cmd_v <= handshake;
      if (handshake) begin
        cmd_q.we    <= bus.req_we[grant_id];
        cmd_q.addr  <= DMEM_WIDTH'(bus.req_addr[grant_id*WIDTH +: WIDTH]);
        cmd_q.wdata <= DMEM_WIDTH'(bus.req_wdata[grant_id*WIDTH +: WIDTH]);
        cmd_q.id    <= ID_MAX_W'(grant_id);
      end
    end
  end

  // Memory drive. Reset also gates the write enable so a write still in
  // the command register when reset arrives never reaches memory.
  assign bus.mem_a  = cmd_q.addr[WIDTH-1:0];
  assign bus.mem_wd = cmd_q.wdata[WIDTH-1:0];
  assign bus.mem_we = cmd_v & cmd_q.we & ~reset;

  // Response register: one-hot completion to the issuing requester,
  // read data only for reads
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= cmd_v ? (N_REQ'(1) << cmd_q.id) : '0;
      rsp_rdata_q <= (cmd_v && !cmd_q.we) ? bus.mem_rd : '0;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small behavioural data memory.
module tb_dmem_arbiter;
  localparam int N = 4;
  localparam int W = 64;

  typedef struct {
    logic [N-1:0]   valid;
    logic [N-1:0]   we;
    logic [N*W-1:0] addr;
    logic [N*W-1:0] wdata;
    logic [N-1:0]   exp_ready;
    logic [N-1:0]   exp_rsp;
    logic [W-1:0]   exp_rdata;
    logic           exp_mem_we;
    logic [1:0]     exp_ptr;
  } vec_t;

  logic       clk;
  logic       reset;
  logic [1:0] rr_ptr;
  logic       do_preload;
  logic [W-1:0] mem_arr [0:255];
  int checks;
  int errors;
  vec_t tbl[$];

  dmem_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

  dmem_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus.slave),
    .rr_ptr (rr_ptr)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural single-port memory: combinational read, write on clock edge
  assign bus.mem_rd = mem_arr[bus.mem_a[7:0]];
  always @(posedge clk) begin
    if (do_preload) begin
      for (int i = 0; i < 256; i++) mem_arr[i] <= '0;
      mem_arr[8'h10] <= 64'hDEAD;
      mem_arr[8'h30] <= 64'h5555;
      for (int i = 0; i < 4; i++) mem_arr[8'h40 + i] <= 64'h100 + 64'(i);
    end else if (bus.mem_we) begin
      mem_arr[bus.mem_a[7:0]] <= bus.mem_wd;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N*W-1:0] fa(input int i, input logic [W-1:0] v);
    logic [N*W-1:0] r;
    r = '0;
    r[i*W +: W] = v;
    return r;
  endfunction

  task automatic add_vec(input logic [N-1:0] valid, input logic [N-1:0] we,
                         input logic [N*W-1:0] addr, input logic [N*W-1:0] wdata,
                         input logic [N-1:0] e_ready, input logic [N-1:0] e_rsp,
                         input logic [W-1:0] e_rdata, input logic e_we,
                         input logic [1:0] e_ptr);
    vec_t v;
    v.valid = valid; v.we = we; v.addr = addr; v.wdata = wdata;
    v.exp_ready = e_ready; v.exp_rsp = e_rsp; v.exp_rdata = e_rdata;
    v.exp_mem_we = e_we; v.exp_ptr = e_ptr;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic [N-1:0] valid, input logic [N-1:0] we,
                       input logic [N*W-1:0] addr, input logic [N*W-1:0] wdata);
    bus.req_valid = valid;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    do_preload = 1'b1;
    reset = 1'b1;
    drive(4'b0100, '0, '0, '0);

    // reset state; ready follows valid even in reset
    step();
    do_preload = 1'b0;
    chk("rst ready", 64'(bus.req_ready), 64'(4'b0100));
    chk("rst rr_ptr", 64'(rr_ptr), 64'd0);
    chk("rst mem_we", 64'(bus.mem_we), 64'd0);
    chk("rst mem_a", bus.mem_a, 64'd0);
    chk("rst mem_wd", bus.mem_wd, 64'd0);
    chk("rst rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst rsp_rdata", bus.rsp_rdata, 64'd0);
    drive('0, '0, '0, '0);
    step();
    reset = 1'b0;

    // single read, write-then-read hazard, wrap-around
    add_vec(4'b0100, 4'b0000, fa(2, 64'h10), '0, 4'b0100, 4'b0000, 64'h0, 1'b0, 2'd0);
    add_vec(4'b0000, 4'b0000, '0, '0, 4'b0000, 4'b0000, 64'h0, 1'b0, 2'd3);
    add_vec(4'b0000, 4'b0000, '0, '0, 4'b0000, 4'b0100, 64'hDEAD, 1'b0, 2'd3);
    add_vec(4'b0001, 4'b0001, fa(0, 64'h20), fa(0, 64'h1234), 4'b0001, 4'b0000, 64'h0, 1'b0, 2'd3);
    add_vec(4'b0010, 4'b0000, fa(1, 64'h20), '0, 4'b0010, 4'b0000, 64'h0, 1'b1, 2'd1);
    add_vec(4'b0000, 4'b0000, '0, '0, 4'b0000, 4'b0001, 64'h0, 1'b0, 2'd2);
    add_vec(4'b0000, 4'b0000, '0, '0, 4'b0000, 4'b0010, 64'h1234, 1'b0, 2'd2);
    add_vec(4'b0100, 4'b0000, fa(2, 64'h10), '0, 4'b0100, 4'b0000, 64'h0, 1'b0, 2'd2);
    add_vec(4'b1001, 4'b0000, fa(0, 64'h40) | fa(3, 64'h43), '0, 4'b1000, 4'b0000, 64'h0, 1'b0, 2'd3);
    add_vec(4'b1001, 4'b0000, fa(0, 64'h40) | fa(3, 64'h43), '0, 4'b0001, 4'b0100, 64'hDEAD, 1'b0, 2'd0);
    add_vec(4'b0000, 4'b0000, '0, '0, 4'b0000, 4'b1000, 64'h103, 1'b0, 2'd1);
    add_vec(4'b0000, 4'b0000, '0, '0, 4'b0000, 4'b0001, 64'h100, 1'b0, 2'd1);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].valid, tbl[i].we, tbl[i].addr, tbl[i].wdata);
      #1;
      chk($sformatf("v%0d ready", i), 64'(bus.req_ready), 64'(tbl[i].exp_ready));
      chk($sformatf("v%0d rsp_valid", i), 64'(bus.rsp_valid), 64'(tbl[i].exp_rsp));
      chk($sformatf("v%0d rsp_rdata", i), bus.rsp_rdata, tbl[i].exp_rdata);
      chk($sformatf("v%0d mem_we", i), 64'(bus.mem_we), 64'(tbl[i].exp_mem_we));
      chk($sformatf("v%0d rr_ptr", i), 64'(rr_ptr), 64'(tbl[i].exp_ptr));
      step();
    end
    drive('0, '0, '0, '0);

    // all four requesters valid continuously from reset: strict rotation
    reset = 1'b1;
    drive(4'b1111, 4'b0000, fa(0, 64'h40) | fa(1, 64'h41) | fa(2, 64'h42) | fa(3, 64'h43), '0);
    step();
    step();
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk($sformatf("rot%0d ready", k), 64'(bus.req_ready), 64'(4'b0001 << (k % 4)));
      chk($sformatf("rot%0d rr_ptr", k), 64'(rr_ptr), 64'(k % 4));
      if (k < 2) begin
        chk($sformatf("rot%0d rsp_valid", k), 64'(bus.rsp_valid), 64'd0);
      end else begin
        chk($sformatf("rot%0d rsp_valid", k), 64'(bus.rsp_valid), 64'(4'b0001 << ((k - 2) % 4)));
        chk($sformatf("rot%0d rsp_rdata", k), bus.rsp_rdata, 64'h100 + 64'((k - 2) % 4));
      end
      step();
    end
    drive('0, '0, '0, '0);
    step();
    step();

    // reset arrives while a write sits in the command register
    drive(4'b0010, 4'b0010, fa(1, 64'h30), fa(1, 64'hFF));
    #1;
    chk("rmf ready", 64'(bus.req_ready), 64'(4'b0010));
    step();
    drive('0, '0, '0, '0);
    reset = 1'b1;
    #1;
    chk("rmf mem_we", 64'(bus.mem_we), 64'd0);
    step();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("rmf%0d rsp_valid", k), 64'(bus.rsp_valid), 64'd0);
      step();
    end
    chk("rmf mem 0x30", mem_arr[8'h30], 64'h5555);
    chk("rmf rr_ptr", 64'(rr_ptr), 64'd0);

    // idle: move pointer to 2, drain, then 10 quiet cycles
    drive(4'b0010, 4'b0000, fa(1, 64'h10), '0);
    step();
    drive('0, '0, '0, '0);
    step();
    step();
    step();
    for (int k = 0; k < 10; k++) begin
      #1;
      chk($sformatf("idle%0d ready", k), 64'(bus.req_ready), 64'd0);
      chk($sformatf("idle%0d mem_we", k), 64'(bus.mem_we), 64'd0);
      chk($sformatf("idle%0d rsp_valid", k), 64'(bus.rsp_valid), 64'd0);
      chk($sformatf("idle%0d rr_ptr", k), 64'(rr_ptr), 64'd2);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
